fifo_wr_arb: RTL and testbench

- Round-robin write-port arbiter that shares one 8-bit, 16-deep FIFO write port between NUM_REQ producers.
- Sits directly in front of the FIFO's wenb/din inputs.
- The FIFO gives a read priority over a write in the same cycle, so this block issues a write only when the FIFO will accept it. No write is ever silently dropped.
- A granted producer may stream up to BURST_LEN writes before the grant rotates.

---
 rtl/fifo_wr_arb_pkg.sv | 34 +++
 rtl/fifo_wr_arb_rr_pick.sv | 26 ++
 rtl/fifo_wr_arb.sv | 143 ++++++++++++++
 tb/tb_fifo_wr_arb.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types, default sizes and the rotating-priority helper for fifo_wr_arb.
// Optional checkers in the top are enabled by FIFO_WR_ARB_ASSERT_EN.
package fifo_wr_arb_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_e;

  localparam int ARB_NUM_REQ   = 4;
  localparam int ARB_DATA_W    = 8;
  localparam int ARB_BURST_LEN = 4;
  localparam int ARB_MAX_REQ   = 8;

  // First set bit of valid[n-1:0] at or after start, wrapping modulo n.
  function automatic logic [ARB_MAX_REQ-1:0] rr_next(
    input logic [ARB_MAX_REQ-1:0] valid,
    input int                     start,
    input int                     n
  );
    logic [ARB_MAX_REQ-1:0] w;
    int                     idx;
    logic [2:0]             ix;
    w = '0;
    for (int k = 0; k < ARB_MAX_REQ; k++) begin
      idx = start + k;
      if (idx >= n) idx = idx - n;
      ix = idx[2:0];
      if (k < n && w == '0 && valid[ix]) w[ix] = 1'b1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational rotating priority encoder shared by idle and release arbitration.
// Returns a one-hot winner searching upward from start, plus a found flag.
module rr_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int N  = ARB_NUM_REQ,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  winner,
  output logic          found
);

  logic [ARB_MAX_REQ-1:0] full;
  logic                   unused_full;

  always_comb begin
    full = rr_next(ARB_MAX_REQ'(valid), int'(start), N);
  end

  assign winner      = full[N-1:0];
  assign found       = |winner;
  assign unused_full = ^full;

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter for a single FIFO write port.
// Define FIFO_WR_ARB_ASSERT_EN to compile in SVA checkers and covers.
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ   = ARB_NUM_REQ,
  parameter int DATA_W    = ARB_DATA_W,
  parameter int BURST_LEN = ARB_BURST_LEN
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  input  logic                      fifo_rd_act,
  output logic                      fifo_wenb,
  output logic [DATA_W-1:0]         fifo_din,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BURST_LEN + 1);

  arb_state_e         state, state_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [BW-1:0]      burst_cnt, burst_cnt_n;
  logic [IW-1:0]      rr_ptr, rr_ptr_n;

  logic [IW-1:0]      gidx, g_next, start;
  logic               can_wr, cur_valid, xfer, last, rel;
  logic [NUM_REQ-1:0] winner;
  logic               found;

  always_comb begin
    gidx     = '0;
    fifo_din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gidx     = IW'(i);
        fifo_din = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign can_wr    = ~fifo_full & ~fifo_rd_act;
  assign cur_valid = |(grant & req_valid);
  assign xfer      = cur_valid & can_wr;
  assign last      = burst_cnt == BW'(BURST_LEN - 1);
  assign g_next    = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
  // A stalled cycle holds everything, including a pending withdrawal.
  assign rel       = (state == GRANT) & can_wr & (~cur_valid | last);
  assign start     = (state == IDLE) ? rr_ptr : g_next;

  assign req_ready = grant & {NUM_REQ{can_wr}};
  assign fifo_wenb = xfer;
  assign busy      = state == GRANT;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .valid  (req_valid),
    .start  (start),
    .winner (winner),
    .found  (found)
  );

  always_comb begin
    state_n     = state;
    grant_n     = grant;
    burst_cnt_n = burst_cnt;
    rr_ptr_n    = rr_ptr;
    unique case (state)
      IDLE: begin
        burst_cnt_n = '0;
        if (found) begin
          state_n = GRANT;
          grant_n = winner;
        end
      end
      GRANT: begin
        if (xfer) burst_cnt_n = burst_cnt + 1'b1;
        if (rel) begin
          rr_ptr_n    = g_next;
          burst_cnt_n = '0;
          if (found) begin
            grant_n = winner;
          end else begin
            state_n = IDLE;
            grant_n = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      burst_cnt <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      burst_cnt <= burst_cnt_n;
      rr_ptr    <= rr_ptr_n;
    end
  end

`ifdef FIFO_WR_ARB_ASSERT_EN
  a_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(grant));
  a_safe: assert property (@(posedge clk) disable iff (reset)
    fifo_wenb |-> (!fifo_full && !fifo_rd_act));
  a_ready: assert property (@(posedge clk) disable iff (reset)
    $onehot0(req_ready));
  a_hold: assert property (@(posedge clk) disable iff (reset)
    (state == GRANT && !rel) |=> grant == $past(grant));
  m_nostall: assume property (@(posedge clk) disable iff (reset)
    can_wr);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_live
    a_live: assert property (@(posedge clk) disable iff (reset)
      (req_valid[i] && !grant[i]) |->
        ##[0:NUM_REQ*BURST_LEN] (grant[i] || !req_valid[i]));
  end

  c_expire: cover property (@(posedge clk) disable iff (reset)
    xfer && last);
  c_regrant: cover property (@(posedge clk) disable iff (reset)
    rel && found && xfer);
  c_withdraw: cover property (@(posedge clk) disable iff (reset)
    state == GRANT && !cur_valid);
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed table-driven bench for fifo_wr_arb plus multi-cycle corner sequences.
// Expected values are hand-computed constants.
module tb_fifo_wr_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        fifo_full = 1'b0;
  logic        fifo_rd_act = 1'b0;
  logic        fifo_wenb;
  logic [7:0]  fifo_din;
  logic [3:0]  grant;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        full;
    logic        rd;
    logic [3:0]  eg;
    logic        ew;
    logic [7:0]  ed;
    logic [3:0]  er;
    logic        eb;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] wlog[$];
  logic [7:0] exp_log[$];

  fifo_wr_arb #(
    .NUM_REQ   (4),
    .DATA_W    (8),
    .BURST_LEN (4)
  ) dut (
    .clk         (clk),
    .reset       (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_rd_act (fifo_rd_act),
    .fifo_wenb   (fifo_wenb),
    .fifo_din    (fifo_din),
    .grant       (grant),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && fifo_wenb) wlog.push_back(fifo_din);
  end

  function automatic vec_t mk(
    input logic rst_i, input logic [3:0] v, input logic [31:0] d,
    input logic f, input logic r, input logic [3:0] eg,
    input logic ew, input logic [7:0] ed, input logic [3:0] er,
    input logic eb
  );
    vec_t x;
    x.rst = rst_i; x.valid = v; x.data = d; x.full = f; x.rd = r;
    x.eg = eg; x.ew = ew; x.ed = ed; x.er = er; x.eb = eb;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    chk({tag, " grant"}, 32'(grant), 32'(v.eg));
    chk({tag, " wenb"}, 32'(fifo_wenb), 32'(v.ew));
    chk({tag, " din"}, 32'(fifo_din), 32'(v.ed));
    chk({tag, " ready"}, 32'(req_ready), 32'(v.er));
    chk({tag, " busy"}, 32'(busy), 32'(v.eb));
  endtask

  // Entered at posedge+1; drives, checks at posedge+4, returns at next posedge+1.
  task automatic step(input string tag, input vec_t v);
    rst         = v.rst;
    req_valid   = v.valid;
    req_data    = v.data;
    fifo_full   = v.full;
    fifo_rd_act = v.rd;
    #3;
    check_outs(tag, v);
    @(posedge clk);
    #1;
  endtask

  task automatic s(input string tag, input logic [3:0] v,
                   input logic [31:0] d, input logic f, input logic r,
                   input logic [3:0] eg, input logic ew, input logic [7:0] ed,
                   input logic [3:0] er, input logic eb);
    step(tag, mk(1'b0, v, d, f, r, eg, ew, ed, er, eb));
  endtask

  initial begin
    // Single producer streams A0..A5 across a burst boundary with no gap.
    tbl.push_back(mk(0, 4'b0001, 32'h0000_00A0, 0, 0, 4'b0000, 0, 8'h00, 4'b0000, 0));
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(0, 4'b0001, 32'hA0 + 32'(k), 0, 0,
                       4'b0001, 1, 8'hA0 + 8'(k), 4'b0001, 1));
    tbl.push_back(mk(0, 4'b0000, 32'h0000_00A5, 0, 0, 4'b0001, 0, 8'hA5, 4'b0001, 1));
    tbl.push_back(mk(0, 4'b0000, 32'h0000_00A5, 0, 0, 4'b0000, 0, 8'h00, 4'b0000, 0));
    // Synchronous-looking reset row, then all four producers continuously.
    tbl.push_back(mk(1, 4'b0000, 32'h0, 0, 0, 4'b0000, 0, 8'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b1111, 32'h1312_1110, 0, 0, 4'b0000, 0, 8'h00, 4'b0000, 0));
    for (int o = 0; o < 4; o++)
      for (int k = 0; k < 4; k++)
        tbl.push_back(mk(0, 4'b1111, 32'h1312_1110, 0, 0,
                         4'(1 << o), 1, 8'h10 + 8'(o), 4'(1 << o), 1));
    tbl.push_back(mk(0, 4'b1111, 32'h1312_1110, 0, 0, 4'b0001, 1, 8'h10, 4'b0001, 1));
    tbl.push_back(mk(0, 4'b0000, 32'h1312_1110, 0, 0, 4'b0001, 0, 8'h10, 4'b0001, 1));
    tbl.push_back(mk(0, 4'b0000, 32'h1312_1110, 0, 0, 4'b0000, 0, 8'h00, 4'b0000, 0));

    #12;
    chk("reset grant", 32'(grant), 32'h0);
    chk("reset wenb", 32'(fifo_wenb), 32'h0);
    chk("reset ready", 32'(req_ready), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("row%0d", i), tbl[i]);

    wlog.delete();
    // Producer 2 with a 3-cycle full stall; producer 3 waits.
    s("st0", 4'b1100, 32'h3020_0000, 0, 0, 4'b0000, 0, 8'h00, 4'b0000, 0);
    s("st1", 4'b1100, 32'h3020_0000, 0, 0, 4'b0100, 1, 8'h20, 4'b0100, 1);
    s("st2", 4'b1100, 32'h3021_0000, 0, 0, 4'b0100, 1, 8'h21, 4'b0100, 1);
    for (int k = 0; k < 3; k++)
      s("st_full", 4'b1100, 32'h3022_0000, 1, 0, 4'b0100, 0, 8'h22, 4'b0000, 1);
    s("st6", 4'b1100, 32'h3022_0000, 0, 0, 4'b0100, 1, 8'h22, 4'b0100, 1);
    s("st7", 4'b1100, 32'h3023_0000, 0, 0, 4'b0100, 1, 8'h23, 4'b0100, 1);
    // Producer 3 owns; one read-collision cycle holds its data.
    s("rd0", 4'b1000, 32'h3000_0000, 0, 0, 4'b1000, 1, 8'h30, 4'b1000, 1);
    s("rd1", 4'b1000, 32'h3100_0000, 0, 1, 4'b1000, 0, 8'h31, 4'b0000, 1);
    s("rd2", 4'b1000, 32'h3100_0000, 0, 0, 4'b1000, 1, 8'h31, 4'b1000, 1);
    s("rd3", 4'b1000, 32'h3200_0000, 0, 0, 4'b1000, 1, 8'h32, 4'b1000, 1);
    s("rd4", 4'b1010, 32'h3300_4000, 0, 0, 4'b1000, 1, 8'h33, 4'b1000, 1);
    // Producer 1 withdraws after two writes.
    s("wd0", 4'b1010, 32'h3400_4000, 0, 0, 4'b0010, 1, 8'h40, 4'b0010, 1);
    s("wd1", 4'b1010, 32'h3400_4100, 0, 0, 4'b0010, 1, 8'h41, 4'b0010, 1);
    s("wd2", 4'b1000, 32'h3400_4100, 0, 0, 4'b0010, 0, 8'h41, 4'b0010, 1);
    s("wd3", 4'b1000, 32'h3400_0000, 0, 0, 4'b1000, 1, 8'h34, 4'b1000, 1);
    s("both", 4'b1000, 32'h3500_0000, 1, 1, 4'b1000, 0, 8'h35, 4'b0000, 1);
    s("wd5", 4'b1000, 32'h3500_0000, 0, 0, 4'b1000, 1, 8'h35, 4'b1000, 1);

    exp_log = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h31, 8'h32, 8'h33,
                8'h40, 8'h41, 8'h34, 8'h35};
    chk("log size", 32'(wlog.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size(); i++)
      chk($sformatf("log%0d", i),
          (i < wlog.size()) ? 32'(wlog[i]) : 32'hFFFF_FFFF, 32'(exp_log[i]));

    // Asynchronous reset between edges while producer 3 is writing.
    req_valid = 4'b1000;
    req_data  = 32'h3600_0000;
    #1;
    chk("pre_rst grant", 32'(grant), 32'h8);
    chk("pre_rst wenb", 32'(fifo_wenb), 32'h1);
    rst = 1'b1;
    #1;
    chk("arst grant", 32'(grant), 32'h0);
    chk("arst wenb", 32'(fifo_wenb), 32'h0);
    chk("arst ready", 32'(req_ready), 32'h0);
    chk("arst busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    s("post0", 4'b0100, 32'h0050_0000, 0, 0, 4'b0000, 0, 8'h00, 4'b0000, 0);
    s("post1", 4'b0100, 32'h0050_0000, 0, 0, 4'b0100, 1, 8'h50, 4'b0100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
